// File: rtl/image_window_reader.sv
// Streams every 3x3 window of a 30x30 byte image held in four byte-lane RAMs to a consumer.
// Define WINDOW_PAD_EN for a zero-padded same-size scan (30x30 windows centred on each pixel).
module image_window_reader #(
    parameter int unsigned IMG_W  = 30,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned POS_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] img_addr0,
    output logic [ADDR_W-1:0] img_addr1,
    output logic [ADDR_W-1:0] img_addr2,
    output logic [ADDR_W-1:0] img_addr3,
    input  logic [7:0]        img_q0,
    input  logic [7:0]        img_q1,
    input  logic [7:0]        img_q2,
    input  logic [7:0]        img_q3,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [71:0]       win_data,
    output logic [POS_W-1:0]  win_row,
    output logic [POS_W-1:0]  win_col
);

`ifdef WINDOW_PAD_EN
    localparam int unsigned LAST = IMG_W - 1;
    localparam logic signed [15:0] PAD_OFF = 16'sd1;
`else
    localparam int unsigned LAST = IMG_W - 3;
    localparam logic signed [15:0] PAD_OFF = 16'sd0;
`endif
    localparam logic signed [15:0] IMG_S = 16'(IMG_W);
    localparam logic [POS_W-1:0]    LAST_POS = POS_W'(LAST);

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StHold, StFinish} state_t;

    state_t           state;
    logic [1:0]       fk;

    // Read-request metadata, delayed two cycles to line up with RAM data.
    logic             s1_valid, s2_valid;
    logic [1:0]       s1_k, s2_k;
    logic [1:0]       s1_off, s2_off;
    logic [2:0]       s1_mask, s2_mask;

    logic             issue;
    logic [POS_W-1:0] iss_row, iss_col;
    logic [1:0]       iss_k;
    logic [POS_W-1:0] nxt_row, nxt_col;
    logic             last_win;
    logic             handshake;

    logic signed [15:0] r_s, c_s, cj, base, idx;
    logic [2:0]         mask;
    logic [ADDR_W-1:0]  addr_n [4];

    logic [7:0]  q [4];
    logic [23:0] cap_row;
    logic [1:0]  lane;

    assign q[0] = img_q0;
    assign q[1] = img_q1;
    assign q[2] = img_q2;
    assign q[3] = img_q3;

    assign handshake = win_valid && win_ready;

    always_comb begin
        last_win = (win_row == LAST_POS) && (win_col == LAST_POS);
        if (win_col != LAST_POS) begin
            nxt_row = win_row;
            nxt_col = win_col + 1'b1;
        end else begin
            nxt_row = win_row + 1'b1;
            nxt_col = '0;
        end

        issue   = 1'b0;
        iss_row = win_row;
        iss_col = win_col;
        iss_k   = 2'd0;
        case (state)
            StIdle: begin
                if (start) begin
                    issue   = 1'b1;
                    iss_row = '0;
                    iss_col = '0;
                end
            end
            StFetch: begin
                if (fk != 2'd2) begin
                    issue = 1'b1;
                    iss_k = fk + 2'd1;
                end
            end
            StHold: begin
                if (handshake && !last_win) begin
                    issue   = 1'b1;
                    iss_row = nxt_row;
                    iss_col = nxt_col;
                end
            end
            default: ;
        endcase
    end

    // Three consecutive byte indices always land in three distinct banks.
    always_comb begin
        r_s       = $signed(16'(iss_row)) + $signed(16'(iss_k)) - PAD_OFF;
        c_s       = $signed(16'(iss_col)) - PAD_OFF;
        base      = r_s * IMG_S + c_s;
        addr_n[0] = img_addr0;
        addr_n[1] = img_addr1;
        addr_n[2] = img_addr2;
        addr_n[3] = img_addr3;
        mask      = '0;
        idx       = '0;
        cj        = '0;
        for (int j = 0; j < 3; j++) begin
            idx     = base + $signed(16'(j));
            cj      = c_s + $signed(16'(j));
            mask[j] = (r_s >= 16'sd0) && (r_s < IMG_S) && (cj >= 16'sd0) && (cj < IMG_S);
            if (mask[j]) begin
                addr_n[idx[1:0]] = idx[ADDR_W+1:2];
            end
        end
    end

    // Out-of-image pixels (padding only) capture as zero.
    always_comb begin
        cap_row = '0;
        lane    = '0;
        for (int j = 0; j < 3; j++) begin
            lane    = s2_off + 2'(j);
            cap_row = {cap_row[15:0], s2_mask[j] ? q[lane] : 8'h00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            fk        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
            img_addr0 <= '0;
            img_addr1 <= '0;
            img_addr2 <= '0;
            img_addr3 <= '0;
            s1_valid  <= 1'b0;
            s1_k      <= '0;
            s1_off    <= '0;
            s1_mask   <= '0;
            s2_valid  <= 1'b0;
            s2_k      <= '0;
            s2_off    <= '0;
            s2_mask   <= '0;
        end else begin
            done     <= 1'b0;
            s1_valid <= issue;
            s1_k     <= iss_k;
            s1_off   <= base[1:0];
            s1_mask  <= mask;
            s2_valid <= s1_valid;
            s2_k     <= s1_k;
            s2_off   <= s1_off;
            s2_mask  <= s1_mask;

            if (issue) begin
                img_addr0 <= addr_n[0];
                img_addr1 <= addr_n[1];
                img_addr2 <= addr_n[2];
                img_addr3 <= addr_n[3];
            end

            if (s2_valid) begin
                case (s2_k)
                    2'd0:    win_data[71:48] <= cap_row;
                    2'd1:    win_data[47:24] <= cap_row;
                    default: win_data[23:0]  <= cap_row;
                endcase
            end

            case (state)
                StIdle: begin
                    if (start) begin
                        busy    <= 1'b1;
                        win_row <= '0;
                        win_col <= '0;
                        fk      <= '0;
                        state   <= StFetch;
                    end
                end
                StFetch: begin
                    if (fk == 2'd2) begin
                        state <= StDrain;
                    end else begin
                        fk <= fk + 2'd1;
                    end
                end
                StDrain: begin
                    win_valid <= 1'b1;
                    state     <= StHold;
                end
                StHold: begin
                    if (handshake) begin
                        win_valid <= 1'b0;
                        if (last_win) begin
                            done  <= 1'b1;
                            state <= StFinish;
                        end else begin
                            win_row <= nxt_row;
                            win_col <= nxt_col;
                            fk      <= '0;
                            state   <= StFetch;
                        end
                    end
                end
                StFinish: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_image_window_reader.sv
// Bench for image_window_reader: four synchronous byte-lane RAMs plus a pixel-level window
// model driven by randomized ready/start stimulus.
module tb_image_window_reader;

    localparam int W = 30;
`ifdef WINDOW_PAD_EN
    localparam int OFF  = 1;
    localparam int SIDE = 30;
`else
    localparam int OFF  = 0;
    localparam int SIDE = 28;
`endif
    localparam int TOTAL = SIDE * SIDE;

    logic        clk = 1'b0;
    logic        reset, start, win_ready;
    logic        busy, done, win_valid;
    logic [9:0]  img_addr0, img_addr1, img_addr2, img_addr3;
    logic [7:0]  img_q0, img_q1, img_q2, img_q3;
    logic [71:0] win_data;
    logic [4:0]  win_row, win_col;

    logic [7:0] img [W*W];
    logic [7:0] bank0 [1024];
    logic [7:0] bank1 [1024];
    logic [7:0] bank2 [1024];
    logic [7:0] bank3 [1024];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    image_window_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .img_addr0 (img_addr0),
        .img_addr1 (img_addr1),
        .img_addr2 (img_addr2),
        .img_addr3 (img_addr3),
        .img_q0    (img_q0),
        .img_q1    (img_q1),
        .img_q2    (img_q2),
        .img_q3    (img_q3),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_data  (win_data),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        img_q0 <= bank0[img_addr0];
        img_q1 <= bank1[img_addr1];
        img_q2 <= bank2[img_addr2];
        img_q3 <= bank3[img_addr3];
    end

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_image(input bit ramp);
        for (int i = 0; i < W * W; i++) begin
            img[i] = ramp ? 8'(i % 256) : 8'($urandom_range(0, 255));
            case (i % 4)
                0: bank0[i / 4] = img[i];
                1: bank1[i / 4] = img[i];
                2: bank2[i / 4] = img[i];
                default: bank3[i / 4] = img[i];
            endcase
        end
    endtask

    // Window centred per the scan mode; pixels outside the image read as zero.
    function automatic logic [71:0] model_win(input int r, input int c);
        logic [71:0] w;
        logic [7:0]  p;
        int          pr, pc;
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                pr = r - OFF + rr;
                pc = c - OFF + cc;
                p  = (pr >= 0 && pr < W && pc >= 0 && pc < W) ? img[pr * W + pc] : 8'h00;
                w  = {w[63:0], p};
            end
        end
        return w;
    endfunction

    task automatic check_literal(input int r, input int c);
`ifdef WINDOW_PAD_EN
        if (r == 0 && c == 0) check_eq("ramp_win_0_0", win_data, 72'h00_00_00_00_00_01_00_1E_1F);
`else
        if (r == 0 && c == 0) check_eq("ramp_win_0_0", win_data, 72'h00_01_02_1E_1F_20_3C_3D_3E);
        if (r == 0 && c == 1) check_eq("ramp_win_0_1", win_data, 72'h01_02_03_1F_20_21_3D_3E_3F);
        if (r == 27 && c == 27) check_eq("ramp_win_27_27", win_data, 72'h45_46_47_63_64_65_81_82_83);
`endif
    endtask

    task automatic run_scan(input int ready_pct, input int abort_at, input bit timing_chk,
                            input bit stall_chk, input bit ramp);
        int er, ec, n_win, cyc, stall;
        bit pv, pr, seen;
        er = 0; ec = 0; n_win = 0; stall = 0; seen = 0;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check_eq("busy_after_start", busy, 1'b1);
        forever begin
            if (done) begin
                done_cnt++;
                if (timing_chk) check_eq("done_cycle", cyc, TOTAL * 5 + 1);
            end
            if (win_valid) begin
                if (timing_chk && n_win == 0 && !seen) check_eq("first_valid_cycle", cyc, 5);
                check_eq("win_row", win_row, er);
                check_eq("win_col", win_col, ec);
                check_eq("win_data", win_data, model_win(er, ec));
                if (ramp && !seen) check_literal(er, ec);
                seen = 1;
                if (n_win == abort_at) begin
                    start = 1'b0;
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    check_eq("abort_valid", win_valid, 1'b0);
                    check_eq("abort_busy", busy, 1'b0);
                    check_eq("abort_done", done, 1'b0);
                    check_eq("abort_data", win_data, 72'h0);
                    check_eq("abort_pos", {win_row, win_col}, 10'h0);
                    return;
                end
                if (stall_chk && er == 3 && ec == 5 && stall < 10) begin
                    win_ready = 1'b0;
                    stall++;
                end else begin
                    win_ready = ($urandom_range(0, 99) < ready_pct);
                end
            end else begin
                win_ready = 1'($urandom_range(0, 1));
            end
            // Starts while busy must be ignored.
            start = busy && ($urandom_range(0, 15) == 0);
            pv = win_valid;
            pr = win_ready;
            @(posedge clk); #1;
            cyc++;
            if (pv && pr) begin
                n_win++;
                seen = 0;
                ec++;
                if (ec == SIDE) begin
                    ec = 0;
                    er++;
                end
            end
            if (n_win == TOTAL && !busy) break;
            if (cyc > 60000) begin
                check_eq("scan_timeout", cyc, 60000);
                break;
            end
        end
        start = 1'b0;
        if (stall_chk) check_eq("stall_cycles", stall, 10);
        check_eq("window_count", n_win, TOTAL);
        check_eq("done_count", done_cnt, 1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        win_ready = 1'b0;
        load_image(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_valid", win_valid, 1'b0);
        check_eq("rst_data", win_data, 72'h0);
        check_eq("rst_pos", {win_row, win_col}, 10'h0);
        check_eq("rst_addr", {img_addr0, img_addr1, img_addr2, img_addr3}, 40'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_scan(100, -1, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_valid", win_valid, 1'b0);

        load_image(1'b0);
        run_scan(70, -1, 1'b0, 1'b1, 1'b0);

        run_scan(60, 99, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, 0);
        check_eq("abort_idle_busy", busy, 1'b0);

        load_image(1'b1);
        run_scan(80, -1, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
